// File: rtl/argmax_stream_pkg.sv
// Shared types and helpers for the streaming arg-max block.
package argmax_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmax_stream_if.sv
// Score-in / result-out handshake bundle for argmax_stream.
interface argmax_stream_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_bus;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_bus;
  logic [DATA_W-1:0] out_max;
  logic              busy;

  modport master (
    output start, in_valid, in_bus, out_ready,
    input  in_ready, out_valid, out_bus, out_max, busy
  );

  modport slave (
    input  start, in_valid, in_bus, out_ready,
    output in_ready, out_valid, out_bus, out_max, busy
  );
endinterface

// File: rtl/argmax_stream_cmp.sv
// Strict greater-than between an incoming score and the running best.
module argmax_cmp #(
  parameter int DATA_W      = 16,
  parameter int SIGNED_MODE = 1
) (
  input  logic [DATA_W-1:0] new_i,
  input  logic [DATA_W-1:0] best_i,
  output logic              gt_o
);

  if (SIGNED_MODE != 0) begin : g_signed
    assign gt_o = $signed(new_i) > $signed(best_i);
  end else begin : g_unsigned
    assign gt_o = new_i > best_i;
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming arg-max over frames of N_CLASSES scores; one score per cycle.
module argmax_stream
  import argmax_stream_pkg::*;
#(
  parameter int  N_CLASSES   = 10,
  parameter int  DATA_W      = 16,
  parameter int  SIGNED_MODE = 1,
  localparam int IDX_W       = (clog2(N_CLASSES) < 1) ? 1 : clog2(N_CLASSES)
) (
  input  logic              ArgMax_CLOCK,
  input  logic              ArgMax_RESETn,
  input  logic              ArgMax_Start,
  input  logic              ArgMax_InValid,
  output logic              ArgMax_InReady,
  input  logic [DATA_W-1:0] ArgMax_InBUS,
  output logic              ArgMax_OutValid,
  input  logic              ArgMax_OutReady,
  output logic [IDX_W-1:0]  ArgMax_OutBUS,
  output logic [DATA_W-1:0] ArgMax_OutMax,
  output logic              ArgMax_Busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  bidx_q, bidx_d;
  logic [IDX_W-1:0]  oidx_q, oidx_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [DATA_W-1:0] omax_q, omax_d;
  logic              ov_q, ov_d;
  logic              busy_q, busy_d;
  logic              gt;
  logic              take;

  argmax_cmp #(
    .DATA_W     (DATA_W),
    .SIGNED_MODE(SIGNED_MODE)
  ) u_cmp (
    .new_i (ArgMax_InBUS),
    .best_i(best_q),
    .gt_o  (gt)
  );

  // First score of a frame always wins; later ones must be strictly greater.
  assign take = (cnt_q == '0) || gt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    oidx_d  = oidx_q;
    omax_d  = omax_q;
    unique case (state_q)
      IDLE: begin
        if (ArgMax_Start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          best_d  = '0;
          bidx_d  = '0;
        end
      end
      ACCUM: begin
        if (ArgMax_Start) begin
          cnt_d  = '0;
          best_d = '0;
          bidx_d = '0;
        end else if (ArgMax_InValid) begin
          cnt_d = cnt_q + 1'b1;
          if (take) begin
            best_d = ArgMax_InBUS;
            bidx_d = cnt_q;
          end
          if (cnt_q == LAST) begin
            state_d = HOLD;
            oidx_d  = take ? cnt_q : bidx_q;
            omax_d  = take ? ArgMax_InBUS : best_q;
          end
        end
      end
      HOLD: begin
        if (ArgMax_OutReady) begin
          state_d = ArgMax_Start ? ACCUM : IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ov_d   = (state_d == HOLD);
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge ArgMax_CLOCK or negedge ArgMax_RESETn) begin
    if (!ArgMax_RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      oidx_q  <= '0;
      omax_q  <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      oidx_q  <= oidx_d;
      omax_q  <= omax_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  assign ArgMax_InReady  = (state_q == ACCUM);
  assign ArgMax_OutValid = ov_q;
  assign ArgMax_OutBUS   = oidx_q;
  assign ArgMax_OutMax   = omax_q;
  assign ArgMax_Busy     = busy_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream with a frame-level reference scoreboard.
module tb_argmax_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          exp_idx[$];
  logic [15:0] exp_max[$];

  argmax_stream_if #(.DATA_W(16), .IDX_W(4)) a_if ();

  argmax_stream #(
    .N_CLASSES(10), .DATA_W(16), .SIGNED_MODE(1)
  ) dut (
    .ArgMax_CLOCK   (clk),
    .ArgMax_RESETn  (rst_n),
    .ArgMax_Start   (a_if.start),
    .ArgMax_InValid (a_if.in_valid),
    .ArgMax_InReady (a_if.in_ready),
    .ArgMax_InBUS   (a_if.in_bus),
    .ArgMax_OutValid(a_if.out_valid),
    .ArgMax_OutReady(a_if.out_ready),
    .ArgMax_OutBUS  (a_if.out_bus),
    .ArgMax_OutMax  (a_if.out_max),
    .ArgMax_Busy    (a_if.busy)
  );

  logic       st8, v8, rdy8;
  logic [7:0] b8;
  logic       ov_u, ir_u, bz_u, ov_s, ir_s, bz_s;
  logic [1:0] ob_u, ob_s;
  logic [7:0] om_u, om_s;

  argmax_stream #(
    .N_CLASSES(4), .DATA_W(8), .SIGNED_MODE(0)
  ) dut_u (
    .ArgMax_CLOCK(clk), .ArgMax_RESETn(rst_n),
    .ArgMax_Start(st8), .ArgMax_InValid(v8),
    .ArgMax_InReady(ir_u), .ArgMax_InBUS(b8),
    .ArgMax_OutValid(ov_u), .ArgMax_OutReady(rdy8),
    .ArgMax_OutBUS(ob_u), .ArgMax_OutMax(om_u),
    .ArgMax_Busy(bz_u)
  );

  argmax_stream #(
    .N_CLASSES(4), .DATA_W(8), .SIGNED_MODE(1)
  ) dut_s (
    .ArgMax_CLOCK(clk), .ArgMax_RESETn(rst_n),
    .ArgMax_Start(st8), .ArgMax_InValid(v8),
    .ArgMax_InReady(ir_s), .ArgMax_InBUS(b8),
    .ArgMax_OutValid(ov_s), .ArgMax_OutReady(rdy8),
    .ArgMax_OutBUS(ob_s), .ArgMax_OutMax(om_s),
    .ArgMax_Busy(bz_s)
  );

  logic        st2, v2, rdy2;
  logic [15:0] b2;
  logic        ov2, ir2, bz2;
  logic [0:0]  ob2;
  logic [15:0] om2;

  argmax_stream #(
    .N_CLASSES(2), .DATA_W(16), .SIGNED_MODE(1)
  ) dut_2 (
    .ArgMax_CLOCK(clk), .ArgMax_RESETn(rst_n),
    .ArgMax_Start(st2), .ArgMax_InValid(v2),
    .ArgMax_InReady(ir2), .ArgMax_InBUS(b2),
    .ArgMax_OutValid(ov2), .ArgMax_OutReady(rdy2),
    .ArgMax_OutBUS(ob2), .ArgMax_OutMax(om2),
    .ArgMax_Busy(bz2)
  );

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Reference: first strictly-greater signed score wins.
  function automatic void ref_argmax(input int f[10],
                                     output int idx,
                                     output logic [15:0] mx);
    int best;
    int v;
    best = int'($signed(16'(f[0])));
    idx  = 0;
    for (int i = 1; i < 10; i++) begin
      v = int'($signed(16'(f[i])));
      if (v > best) begin
        best = v;
        idx  = i;
      end
    end
    mx = 16'(best);
  endfunction

  always @(negedge clk) begin
    if (rst_n && a_if.out_valid) begin
      if (exp_idx.size() == 0) begin
        chk("spurious_valid", 32'(a_if.out_valid), 32'd0);
      end else begin
        chk("sb_out_bus", 32'(a_if.out_bus), 32'(exp_idx[0]));
        chk("sb_out_max", 32'(a_if.out_max), 32'(exp_max[0]));
        if (a_if.out_ready) begin
          void'(exp_idx.pop_front());
          void'(exp_max.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
  endtask

  task automatic run_frame(input int f[10], input bit gaps,
                           input bit lat, input bit do_start);
    int          ei;
    logic [15:0] em;
    if (do_start) start_pulse();
    for (int i = 0; i < 10; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      a_if.in_valid = 1'b1;
      a_if.in_bus   = 16'(f[i]);
      if (i == 9) begin
        ref_argmax(f, ei, em);
        exp_idx.push_back(ei);
        exp_max.push_back(em);
      end
      step();
      a_if.in_valid = 1'b0;
      if (lat && i == 8) chk("lat_before", 32'(a_if.out_valid), 32'd0);
      if (lat && i == 9) chk("lat_valid", 32'(a_if.out_valid), 32'd1);
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!a_if.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("valid_seen", 32'(a_if.out_valid), 32'd1);
  endtask

  task automatic release_out();
    a_if.out_ready = 1'b1;
    step();
    a_if.out_ready = 1'b0;
    chk("released", 32'(a_if.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int f35[10];
    int f37[10];
    int f38[10];
    int f39[10];
    f35 = '{3, -7, 12, 0, 5, 12, -1, 9, 11, 2};
    f37 = '{-100, 50, 50, -3, 7, 49, 0, 50, -200, 1};
    f38 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    f39 = '{-5, -9, -5, -20, -1, -1, -30, -2, -8, -100};

    rst_n = 1'b0;
    a_if.start = 1'b0; a_if.in_valid = 1'b0;
    a_if.in_bus = '0; a_if.out_ready = 1'b0;
    st8 = 1'b0; v8 = 1'b0; rdy8 = 1'b0; b8 = '0;
    st2 = 1'b0; v2 = 1'b0; rdy2 = 1'b0; b2 = '0;
    step();
    step();
    chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_if.in_ready), 32'd0);
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    chk("rst_out_bus", 32'(a_if.out_bus), 32'd0);
    chk("rst_out_max", 32'(a_if.out_max), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic frame, tie at index 5 must not win
    run_frame(f35, 1'b0, 1'b1, 1'b1);
    chk("f35_bus", 32'(a_if.out_bus), 32'd2);
    chk("f35_max", 32'(a_if.out_max), 32'd12);
    step();
    release_out();
    chk("idle_busy", 32'(a_if.busy), 32'd0);
    chk("idle_in_ready", 32'(a_if.in_ready), 32'd0);
    chk("keep_bus", 32'(a_if.out_bus), 32'd2);
    chk("keep_max", 32'(a_if.out_max), 32'd12);

    // Gapped input, stalled consumer, ignored Start and data in HOLD
    run_frame(f37, 1'b1, 1'b0, 1'b1);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      a_if.start    = (k == 2);
      a_if.in_valid = 1'b1;
      a_if.in_bus   = 16'h7FFF;
      step();
      a_if.start = 1'b0;
      chk("hold_in_ready", 32'(a_if.in_ready), 32'd0);
      chk("hold_busy", 32'(a_if.busy), 32'd1);
      chk("hold_valid", 32'(a_if.out_valid), 32'd1);
      chk("hold_bus", 32'(a_if.out_bus), 32'd1);
    end
    a_if.in_valid = 1'b0;
    release_out();

    // Abort after four large scores; Start-cycle data is dropped
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_bus   = 16'd20000;
      step();
    end
    a_if.start  = 1'b1;
    a_if.in_bus = 16'd30000;
    step();
    a_if.start    = 1'b0;
    a_if.in_valid = 1'b0;
    chk("abort_in_ready", 32'(a_if.in_ready), 32'd1);
    run_frame(f38, 1'b0, 1'b0, 1'b0);
    wait_valid();
    chk("f38_bus", 32'(a_if.out_bus), 32'd9);
    chk("f38_max", 32'(a_if.out_max), 32'd10);
    release_out();

    // Asynchronous reset during the sixth transfer
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_bus   = 16'(100 + i);
      step();
    end
    a_if.in_bus = 16'd7;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_bus", 32'(a_if.out_bus), 32'd0);
    chk("arst_out_max", 32'(a_if.out_max), 32'd0);
    chk("arst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("arst_in_ready", 32'(a_if.in_ready), 32'd0);
    chk("arst_busy", 32'(a_if.busy), 32'd0);
    a_if.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    run_frame(f39, 1'b0, 1'b0, 1'b1);
    wait_valid();
    chk("f39_bus", 32'(a_if.out_bus), 32'd4);
    chk("f39_max", 32'(a_if.out_max), 32'hFFFF);
    release_out();

    // Same 8-bit stream, unsigned vs signed interpretation
    st8 = 1'b1;
    step();
    st8 = 1'b0;
    v8  = 1'b1;
    b8 = 8'h80; step();
    b8 = 8'h7F; step();
    b8 = 8'h00; step();
    b8 = 8'h10; step();
    v8 = 1'b0;
    chk("u_valid", 32'(ov_u), 32'd1);
    chk("u_bus", 32'(ob_u), 32'd0);
    chk("u_max", 32'(om_u), 32'h80);
    chk("s_valid", 32'(ov_s), 32'd1);
    chk("s_bus", 32'(ob_s), 32'd1);
    chk("s_max", 32'(om_s), 32'h7F);
    rdy8 = 1'b1;
    step();
    rdy8 = 1'b0;
    chk("u_released", 32'(ov_u), 32'd0);
    chk("s_released", 32'(ov_s), 32'd0);

    // Two-class frames back to back through Start+OutReady in HOLD
    st2 = 1'b1;
    step();
    st2 = 1'b0;
    v2  = 1'b1;
    b2 = 16'd5; step();
    b2 = 16'd9; step();
    chk("n2a_valid", 32'(ov2), 32'd1);
    chk("n2a_bus", 32'(ob2), 32'd1);
    chk("n2a_max", 32'(om2), 32'd9);
    st2 = 1'b1; rdy2 = 1'b1; b2 = 16'd100;
    step();
    st2 = 1'b0; rdy2 = 1'b0;
    chk("n2_rearm_valid", 32'(ov2), 32'd0);
    chk("n2_rearm_ready", 32'(ir2), 32'd1);
    chk("n2_rearm_busy", 32'(bz2), 32'd1);
    b2 = 16'hFFFD; step();
    b2 = 16'hFFFD; step();
    v2 = 1'b0;
    chk("n2b_valid", 32'(ov2), 32'd1);
    chk("n2b_bus", 32'(ob2), 32'd0);
    chk("n2b_max", 32'(om2), 32'hFFFD);
    rdy2 = 1'b1;
    step();
    rdy2 = 1'b0;
    chk("n2b_released", 32'(ov2), 32'd0);

    step();
    chk("sb_drained", 32'(exp_idx.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
